can_error_frame_tx: RTL and testbench

- Transmit-side counterpart to the bus-side frame-form checkers.
- When the controller's error monitors flag an error, this block serializes a CAN error frame onto the TX line, bit-timed with the codebase's clocks-per-bit scheme:
  - active or passive error flag
  - error delimiter with superposition wait
  - intermission
- Sits between the error-monitor aggregation logic and the TX pin mux.
- Reports the field currently being driven using the shared 6-bit frame-field code.

---
 rtl/can_error_frame_tx_if.sv | 43 ++++
 rtl/can_error_frame_tx.sv | 186 ++++++++++++++++++
 tb/tb_can_error_frame_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/can_error_frame_tx_if.sv
// can_error_frame_tx_if
//   Handshake and bus signals between the error-monitor aggregation logic
//   (master) and the CAN error/overload frame transmitter (slave).
//   Define CAN_OVERLOAD_FRAME_EN to add the i_overload_req request line.
//
//   i_error_req      request to send an error frame (one cycle)
//   i_error_passive  1 = recessive error flag, latched at acceptance
//   i_overload_req   request to send an overload frame (CAN_OVERLOAD_FRAME_EN only)
//   i_Rx_Data        sampled bus level, 0 = dominant
//   o_Tx_Data        TX bit, 0 = dominant, idles at 1
//   o_busy           frame in progress
//   o_done           one-cycle pulse after the intermission
//   o_bus_stuck      sticky dominant-wait overflow flag
//   o_frame_field    6-bit frame-field code of the field being driven
interface can_error_frame_tx_if;
    logic       i_error_req;
    logic       i_error_passive;
`ifdef CAN_OVERLOAD_FRAME_EN
    logic       i_overload_req;
`endif
    logic       i_Rx_Data;
    logic       o_Tx_Data;
    logic       o_busy;
    logic       o_done;
    logic       o_bus_stuck;
    logic [5:0] o_frame_field;

    modport master (
`ifdef CAN_OVERLOAD_FRAME_EN
        output i_overload_req,
`endif
        output i_error_req, i_error_passive, i_Rx_Data,
        input  o_Tx_Data, o_busy, o_done, o_bus_stuck, o_frame_field
    );

    modport slave (
`ifdef CAN_OVERLOAD_FRAME_EN
        input  i_overload_req,
`endif
        input  i_error_req, i_error_passive, i_Rx_Data,
        output o_Tx_Data, o_busy, o_done, o_bus_stuck, o_frame_field
    );
endinterface

// File: rtl/can_error_frame_tx.sv
// can_error_frame_tx
//   Serializes a CAN error frame (error flag, delimiter with superposition
//   wait, intermission) onto the TX line when an error is requested.
//   Bits are CLKS_PER_BIT clocks long; the bus is sampled mid-bit.
//   Define CAN_OVERLOAD_FRAME_EN to also accept overload-frame requests
//   (dominant flag, field code 31); an error request wins a tie.
//
//   i_Clock  system clock
//   i_Reset  asynchronous active-high reset
//   bus      can_error_frame_tx_if.slave: requests, bus sample, TX bit,
//            busy/done/stuck status and frame-field code
module can_error_frame_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FLAG_BITS    = 6,
    parameter int DELIM_BITS   = 8,
    parameter int IFS_BITS     = 3,
    parameter int MAX_DOM_WAIT = 14
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    can_error_frame_tx_if.slave   bus
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAXB = (FLAG_BITS > DELIM_BITS) ?
                          ((FLAG_BITS > IFS_BITS) ? FLAG_BITS : IFS_BITS) :
                          ((DELIM_BITS > IFS_BITS) ? DELIM_BITS : IFS_BITS);
    localparam int BW   = $clog2(MAXB + 1);
    localparam int DW   = $clog2(MAX_DOM_WAIT + 1);

    localparam logic [5:0] FF_IDLE  = 6'd0;
    localparam logic [5:0] FF_FLAG  = 6'd27;
    localparam logic [5:0] FF_DWAIT = 6'd28;
    localparam logic [5:0] FF_DELIM = 6'd29;
    localparam logic [5:0] FF_IFS   = 6'd30;
`ifdef CAN_OVERLOAD_FRAME_EN
    localparam logic [5:0] FF_OFLAG = 6'd31;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_DWAIT,
        S_DELIM,
        S_IFS
    } state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] dom_cnt;
    logic          rx_mid;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          stuck_q;
    logic [5:0]    field_q;
    logic          bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    assign bus.o_Tx_Data     = tx_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_bus_stuck   = stuck_q;
    assign bus.o_frame_field = field_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            dom_cnt <= '0;
            rx_mid  <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stuck_q <= 1'b0;
            field_q <= FF_IDLE;
        end else begin
            done_q <= 1'b0;

            if (clk_cnt == CW'(CLKS_PER_BIT / 2))
                rx_mid <= bus.i_Rx_Data;

            if (state != S_IDLE)
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    dom_cnt <= '0;
                    // done_q gating keeps a request that overlaps the done
                    // pulse from restarting the block.
                    if (!done_q && bus.i_error_req) begin
                        state   <= S_FLAG;
                        busy_q  <= 1'b1;
                        stuck_q <= 1'b0;
                        tx_q    <= bus.i_error_passive;
                        field_q <= FF_FLAG;
                    end
`ifdef CAN_OVERLOAD_FRAME_EN
                    else if (!done_q && bus.i_overload_req) begin
                        state   <= S_FLAG;
                        busy_q  <= 1'b1;
                        stuck_q <= 1'b0;
                        tx_q    <= 1'b0;
                        field_q <= FF_OFLAG;
                    end
`endif
                end

                // Flag level and code were fixed at acceptance; only timing here.
                S_FLAG: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(FLAG_BITS - 1)) begin
                            state   <= S_DWAIT;
                            bit_cnt <= '0;
                            dom_cnt <= '0;
                            tx_q    <= 1'b1;
                            field_q <= FF_DWAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                // A recessive mid-bit sample makes this bit delimiter bit 1.
                S_DWAIT: begin
                    if (bit_end) begin
                        if (rx_mid) begin
                            bit_cnt <= '0;
                            if (DELIM_BITS > 1) begin
                                state   <= S_DELIM;
                                field_q <= FF_DELIM;
                            end else begin
                                state   <= S_IFS;
                                field_q <= FF_IFS;
                            end
                        end else if (dom_cnt == DW'(MAX_DOM_WAIT - 1)) begin
                            stuck_q <= 1'b1;
                            dom_cnt <= '0;
                        end else begin
                            dom_cnt <= dom_cnt + 1'b1;
                        end
                    end
                end

                S_DELIM: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(DELIM_BITS - 2)) begin
                            state   <= S_IFS;
                            bit_cnt <= '0;
                            field_q <= FF_IFS;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                S_IFS: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(IFS_BITS - 1)) begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            field_q <= FF_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    field_q <= FF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_error_frame_tx.sv
// tb_can_error_frame_tx
//   Bench for can_error_frame_tx. The expected waveform of each frame is
//   derived from field lengths in bits (flag, dominant wait, delimiter,
//   intermission) and the clock offset since acceptance.
module tb_can_error_frame_tx;
    localparam int CPB  = 10;
    localparam int FB   = 6;
    localparam int DB   = 8;
    localparam int IB   = 3;
    localparam int MAXW = 14;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    can_error_frame_tx_if bus ();

    can_error_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .FLAG_BITS    (FB),
        .DELIM_BITS   (DB),
        .IFS_BITS     (IB),
        .MAX_DOM_WAIT (MAXW)
    ) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " tx"},    32'(bus.o_Tx_Data),     32'd1);
        chk({tag, " busy"},  32'(bus.o_busy),        32'd0);
        chk({tag, " field"}, 32'(bus.o_frame_field), 32'd0);
    endtask

    // kind: 0 error, 1 overload, 2 both at once. d: dominant bits held in
    // the delimiter wait. abort_at: offset at which reset is pulsed (-1 none).
    task automatic run_frame(input int kind, input bit passive, input int d,
                             input bit poke_mid, input bit poke_done, input int abort_at);
        int flag_end, dw_end, dl_end, len;
        bit lvl, exp_tx, exp_stuck;
        int exp_f;
        flag_end = FB * CPB;
        dw_end   = flag_end + (d + 1) * CPB;
        dl_end   = dw_end + (DB - 1) * CPB;
        len      = dl_end + IB * CPB;
        lvl      = (kind == 1) ? 1'b0 : passive;

        bus.i_error_req     = (kind != 1);
        bus.i_error_passive = passive;
`ifdef CAN_OVERLOAD_FRAME_EN
        bus.i_overload_req  = (kind != 0);
`endif
        step();
        bus.i_error_req     = 1'b0;
        bus.i_error_passive = ~passive;
`ifdef CAN_OVERLOAD_FRAME_EN
        bus.i_overload_req  = 1'b0;
`endif
        for (int t = 0; t <= len; t++) begin
            if (t > 0) step();
            if (t == len) begin
                chk($sformatf("done t=%0d", t),  32'(bus.o_done),        32'd1);
                chk($sformatf("busy t=%0d", t),  32'(bus.o_busy),        32'd0);
                chk($sformatf("tx t=%0d", t),    32'(bus.o_Tx_Data),     32'd1);
                chk($sformatf("field t=%0d", t), 32'(bus.o_frame_field), 32'd0);
            end else begin
                exp_tx = (t < flag_end) ? lvl : 1'b1;
                if (t < flag_end)    exp_f = (kind == 1) ? 31 : 27;
                else if (t < dw_end) exp_f = 28;
                else if (t < dl_end) exp_f = 29;
                else                 exp_f = 30;
                chk($sformatf("tx t=%0d", t),    32'(bus.o_Tx_Data),     32'(exp_tx));
                chk($sformatf("field t=%0d", t), 32'(bus.o_frame_field), exp_f);
                chk($sformatf("busy t=%0d", t),  32'(bus.o_busy),        32'd1);
                chk($sformatf("done t=%0d", t),  32'(bus.o_done),        32'd0);
            end
            exp_stuck = (d >= MAXW) && (t >= flag_end + MAXW * CPB);
            chk($sformatf("stuck t=%0d", t), 32'(bus.o_bus_stuck), 32'(exp_stuck));

            if (t == abort_at) begin
                #2 i_Reset = 1'b1;
                #1;
                check_idle("async reset");
                chk("async reset done", 32'(bus.o_done), 32'd0);
                step();
                step();
                i_Reset = 1'b0;
                bus.i_Rx_Data = 1'b1;
                step();
                check_idle("after reset");
                return;
            end

            // bus level for the coming cycle
            if (t < flag_end)               bus.i_Rx_Data = lvl;
            else if (t < flag_end + d * CPB) bus.i_Rx_Data = 1'b0;
            else                            bus.i_Rx_Data = 1'b1;
            bus.i_error_req = (poke_mid && t == 20) || (poke_done && t == len);
        end
        step();
        bus.i_error_req = 1'b0;
        chk("req on done ignored busy",  32'(bus.o_busy),        32'd0);
        chk("req on done ignored field", 32'(bus.o_frame_field), 32'd0);
        chk("no second done",            32'(bus.o_done),        32'd0);
    endtask

    initial begin
        bus.i_error_req     = 1'b0;
        bus.i_error_passive = 1'b0;
        bus.i_Rx_Data       = 1'b1;
`ifdef CAN_OVERLOAD_FRAME_EN
        bus.i_overload_req  = 1'b0;
`endif
        #12;
        check_idle("in reset");
        chk("in reset done",  32'(bus.o_done),      32'd0);
        chk("in reset stuck", 32'(bus.o_bus_stuck), 32'd0);
        step();
        i_Reset = 1'b0;
        step();
        step();
        check_idle("idle");

        run_frame(0, 1'b0, 0,    1'b0, 1'b0, -1);  // active, bus follows
        run_frame(0, 1'b1, 0,    1'b0, 1'b0, -1);  // passive
        run_frame(0, 1'b0, 3,    1'b0, 1'b0, -1);  // superposition wait
        run_frame(0, 1'b0, MAXW, 1'b0, 1'b0, -1);  // stuck
        chk("stuck sticky in idle", 32'(bus.o_bus_stuck), 32'd1);
        run_frame(0, 1'b1, 0,    1'b0, 1'b0, -1);  // stuck clears on accept
        run_frame(0, 1'b0, 1,    1'b1, 1'b1, -1);  // ignored extra requests
        for (int i = 0; i < 6; i++)
            run_frame(0, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        run_frame(0, 1'b0, 0, 1'b0, 1'b0, FB * CPB + CPB + 25);  // reset mid-delimiter
`ifdef CAN_OVERLOAD_FRAME_EN
        run_frame(2, 1'b1, 0, 1'b0, 1'b0, -1);  // error wins the tie
        run_frame(1, 1'b1, 2, 1'b0, 1'b0, -1);  // overload flag is dominant
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
